// File: rtl/msrv32_trap_arbiter.sv
`default_nettype none
// ============================================================================
// msrv32_trap_arbiter
// Machine-mode trap arbiter: prioritises exceptions and interrupts, and
// sequences MRET, WFI sleep/wake and trap entry.
// Revision: 1.0
// ============================================================================
module msrv32_trap_arbiter #(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int CAUSE_W       = 5
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic                     stall_in,
  input  logic                     illegal_instr_in,
  input  logic                     misaligned_instr_in,
  input  logic                     misaligned_load_in,
  input  logic                     misaligned_store_in,
  input  logic                     ecall_in,
  input  logic                     ebreak_in,
  input  logic                     mret_in,
  input  logic                     wfi_in,
  input  logic                     mie_in,
  input  logic                     meie_in,
  input  logic                     mtie_in,
  input  logic                     msie_in,
  input  logic                     e_irq_in,
  input  logic                     t_irq_in,
  input  logic                     s_irq_in,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq_in,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq_en_in,
  output logic [1:0]               pc_src_out,
  output logic                     flush_out,
  output logic                     trap_taken_out,
  output logic                     i_or_e_out,
  output logic                     set_cause_out,
  output logic [CAUSE_W-1:0]       cause_out,
  output logic                     set_epc_out,
  output logic                     instret_inc_out,
  output logic                     mie_clear_out,
  output logic                     mie_set_out,
  output logic                     misaligned_exception_out,
  output logic                     sleep_out
);

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_TRAP   = 2'd1,
    S_RETURN = 2'd2,
    S_SLEEP  = 2'd3
  } state_t;

  localparam logic [1:0] c_pc_boot = 2'b00;
  localparam logic [1:0] c_pc_mepc = 2'b01;
  localparam logic [1:0] c_pc_trap = 2'b10;
  localparam logic [1:0] c_pc_next = 2'b11;

  state_t                   r_state;
  logic                     w_exc;
  logic                     w_exc_misaligned;
  logic [CAUSE_W-1:0]       w_exc_code;
  logic [CAUSE_W-1:0]       w_irq_code;
  logic [NUM_LOCAL_IRQ-1:0] w_local_act;
  logic                     w_irq_pend;
  logic                     w_normal_go;
  logic                     w_take_exc;
  logic                     w_take_irq;

  assign w_local_act = local_irq_in & local_irq_en_in;
  assign w_irq_pend  = (e_irq_in & meie_in) | (s_irq_in & msie_in) |
                       (t_irq_in & mtie_in) | (|w_local_act);
  assign w_exc       = misaligned_instr_in | illegal_instr_in | ebreak_in |
                       ecall_in | misaligned_load_in | misaligned_store_in;

  always_comb begin
    w_exc_code = '0;
    if (misaligned_instr_in)      w_exc_code = CAUSE_W'(0);
    else if (illegal_instr_in)    w_exc_code = CAUSE_W'(2);
    else if (ebreak_in)           w_exc_code = CAUSE_W'(3);
    else if (ecall_in)            w_exc_code = CAUSE_W'(11);
    else if (misaligned_load_in)  w_exc_code = CAUSE_W'(4);
    else if (misaligned_store_in) w_exc_code = CAUSE_W'(6);
    w_exc_misaligned = misaligned_instr_in |
                       (~illegal_instr_in & ~ebreak_in & ~ecall_in &
                        (misaligned_load_in | misaligned_store_in));
  end

  // Later assignments override earlier ones, so lowest priority goes first.
  always_comb begin
    w_irq_code = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (w_local_act[i]) w_irq_code = CAUSE_W'(16 + i);
    end
    if (t_irq_in & mtie_in) w_irq_code = CAUSE_W'(7);
    if (s_irq_in & msie_in) w_irq_code = CAUSE_W'(3);
    if (e_irq_in & meie_in) w_irq_code = CAUSE_W'(11);
  end

  // A sleeping core ignores exceptions and stall; only interrupts wake it.
  assign w_normal_go = (r_state == S_NORMAL) & ~stall_in;
  assign w_take_exc  = w_normal_go & w_exc;
  assign w_take_irq  = w_irq_pend & mie_in &
                       ((w_normal_go & ~w_exc) | (r_state == S_SLEEP));

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state                  <= S_NORMAL;
      pc_src_out               <= c_pc_boot;
      flush_out                <= 1'b0;
      trap_taken_out           <= 1'b0;
      i_or_e_out               <= 1'b0;
      set_cause_out            <= 1'b0;
      cause_out                <= '0;
      set_epc_out              <= 1'b0;
      instret_inc_out          <= 1'b0;
      mie_clear_out            <= 1'b0;
      mie_set_out              <= 1'b0;
      misaligned_exception_out <= 1'b0;
      sleep_out                <= 1'b0;
    end else begin
      flush_out                <= 1'b0;
      trap_taken_out           <= 1'b0;
      set_cause_out            <= 1'b0;
      set_epc_out              <= 1'b0;
      instret_inc_out          <= 1'b0;
      mie_clear_out            <= 1'b0;
      mie_set_out              <= 1'b0;
      misaligned_exception_out <= 1'b0;
      sleep_out                <= 1'b0;

      if (w_take_exc | w_take_irq) begin
        flush_out                <= 1'b1;
        trap_taken_out           <= 1'b1;
        set_cause_out            <= 1'b1;
        set_epc_out              <= 1'b1;
        mie_clear_out            <= 1'b1;
        i_or_e_out               <= w_take_irq;
        cause_out                <= w_take_exc ? w_exc_code : w_irq_code;
        misaligned_exception_out <= w_take_exc & w_exc_misaligned;
        pc_src_out               <= c_pc_trap;
        r_state                  <= S_TRAP;
      end else begin
        case (r_state)
          S_NORMAL: begin
            if (!stall_in) begin
              pc_src_out      <= c_pc_next;
              instret_inc_out <= 1'b1;
              if (mret_in) begin
                flush_out   <= 1'b1;
                mie_set_out <= 1'b1;
                pc_src_out  <= c_pc_mepc;
                r_state     <= S_RETURN;
              end else if (wfi_in && !w_irq_pend) begin
                sleep_out <= 1'b1;
                r_state   <= S_SLEEP;
              end
            end
          end
          S_SLEEP: begin
            pc_src_out <= c_pc_next;
            if (w_irq_pend) begin
              r_state <= S_NORMAL;
            end else begin
              sleep_out <= 1'b1;
            end
          end
          default: begin
            pc_src_out <= c_pc_next;
            r_state    <= S_NORMAL;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_trap_arbiter.sv
`default_nettype none
// ============================================================================
// tb_msrv32_trap_arbiter
// Scoreboard bench: expected output vectors queued with stimulus, popped per cycle.
// Revision: 1.0
// ============================================================================
module tb_msrv32_trap_arbiter;

  typedef struct packed {
    logic [1:0] pc;
    logic       flush;
    logic       trap;
    logic       ioe;
    logic       setc;
    logic [4:0] cause;
    logic       sepc;
    logic       inst;
    logic       mclr;
    logic       mset;
    logic       mis;
    logic       slp;
  } out_t;

  logic       clk_in = 1'b0;
  logic       reset_n_in = 1'b0;
  logic       stall_in = 1'b0;
  logic       illegal_instr_in = 1'b0, misaligned_instr_in = 1'b0;
  logic       misaligned_load_in = 1'b0, misaligned_store_in = 1'b0;
  logic       ecall_in = 1'b0, ebreak_in = 1'b0, mret_in = 1'b0, wfi_in = 1'b0;
  logic       mie_in = 1'b0, meie_in = 1'b0, mtie_in = 1'b0, msie_in = 1'b0;
  logic       e_irq_in = 1'b0, t_irq_in = 1'b0, s_irq_in = 1'b0;
  logic [3:0] local_irq_in = '0, local_irq_en_in = '0;
  logic [1:0] pc_src_out;
  logic       flush_out, trap_taken_out, i_or_e_out, set_cause_out;
  logic [4:0] cause_out;
  logic       set_epc_out, instret_inc_out, mie_clear_out, mie_set_out;
  logic       misaligned_exception_out, sleep_out;

  out_t  obs;
  out_t  sb[$];
  string nm[$];
  int    n_chk = 0;
  int    n_pass = 0;
  logic [4:0] cc = '0;

  always #5 clk_in = ~clk_in;

  msrv32_trap_arbiter #(.NUM_LOCAL_IRQ(4), .CAUSE_W(5)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .stall_in(stall_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .ecall_in(ecall_in), .ebreak_in(ebreak_in), .mret_in(mret_in), .wfi_in(wfi_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .e_irq_in(e_irq_in), .t_irq_in(t_irq_in), .s_irq_in(s_irq_in),
    .local_irq_in(local_irq_in), .local_irq_en_in(local_irq_en_in),
    .pc_src_out(pc_src_out), .flush_out(flush_out), .trap_taken_out(trap_taken_out),
    .i_or_e_out(i_or_e_out), .set_cause_out(set_cause_out), .cause_out(cause_out),
    .set_epc_out(set_epc_out), .instret_inc_out(instret_inc_out),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .misaligned_exception_out(misaligned_exception_out), .sleep_out(sleep_out)
  );

  assign obs = {pc_src_out, flush_out, trap_taken_out, i_or_e_out, set_cause_out,
                cause_out, set_epc_out, instret_inc_out, mie_clear_out, mie_set_out,
                misaligned_exception_out, sleep_out};

  // i_or_e is only meaningful alongside set_cause
  function automatic out_t norm(input out_t o);
    norm = o;
    if (!o.setc) norm.ioe = 1'b0;
  endfunction

  function automatic out_t o_rst();
    o_rst = '0;
  endfunction

  function automatic out_t o_run(input logic [4:0] c);
    o_run = '0; o_run.pc = 2'b11; o_run.cause = c; o_run.inst = 1'b1;
  endfunction

  function automatic out_t o_wfi(input logic [4:0] c, input logic s);
    o_wfi = o_run(c); o_wfi.slp = s;
  endfunction

  function automatic out_t o_idle(input logic [4:0] c, input logic s);
    o_idle = '0; o_idle.pc = 2'b11; o_idle.cause = c; o_idle.slp = s;
  endfunction

  function automatic out_t o_trap(input logic [4:0] c, input logic ioe, input logic mis);
    o_trap = '0; o_trap.pc = 2'b10; o_trap.flush = 1'b1; o_trap.trap = 1'b1;
    o_trap.ioe = ioe; o_trap.setc = 1'b1; o_trap.cause = c; o_trap.sepc = 1'b1;
    o_trap.mclr = 1'b1; o_trap.mis = mis;
  endfunction

  function automatic out_t o_ret(input logic [4:0] c);
    o_ret = '0; o_ret.pc = 2'b01; o_ret.flush = 1'b1; o_ret.mset = 1'b1;
    o_ret.inst = 1'b1; o_ret.cause = c;
  endfunction

  task automatic expect_(input out_t v, input string n);
    sb.push_back(v);
    nm.push_back(n);
  endtask

  task automatic test_reset();
    out_t e; string s;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: expect_(o_rst(), "reset_state");
        1: begin reset_n_in = 1'b1; stall_in = 1'b1; expect_(o_rst(), "stall_holds_boot_pc"); end
        default: begin stall_in = 1'b0; expect_(o_run(5'd0), "first_normal"); end
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_sleep_reset();
    out_t e; string s;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin wfi_in = 1'b1; expect_(o_wfi(cc, 1'b1), "wfi_enter_sleep"); end
        1: begin wfi_in = 1'b0; expect_(o_idle(cc, 1'b1), "sleep_hold"); end
        2: expect_(o_rst(), "async_reset_in_sleep");
        default: begin reset_n_in = 1'b1; cc = 5'd0; expect_(o_run(cc), "normal_after_reset"); end
      endcase
      if (k == 2) begin
        #2 reset_n_in = 1'b0;
        #1;
      end else begin
        @(posedge clk_in); #1;
      end
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_exc_priority();
    out_t e; string s;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin
          illegal_instr_in = 1'b1; misaligned_load_in = 1'b1;
          e_irq_in = 1'b1; meie_in = 1'b1; mie_in = 1'b1;
          cc = 5'd2; expect_(o_trap(cc, 1'b0, 1'b0), "illegal_beats_load_and_irq");
        end
        1: begin illegal_instr_in = 1'b0; misaligned_load_in = 1'b0; expect_(o_idle(cc, 1'b0), "trap_state"); end
        2: begin cc = 5'd11; expect_(o_trap(cc, 1'b1, 1'b0), "external_irq"); end
        3: begin e_irq_in = 1'b0; meie_in = 1'b0; expect_(o_idle(cc, 1'b0), "trap_state_irq"); end
        default: expect_(o_run(cc), "normal_after_trap");
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_exc_table();
    out_t e; string s;
    logic [5:0] tv [4] = '{6'b100110, 6'b001100, 6'b000110, 6'b000011};
    logic [4:0] tc [4] = '{5'd0, 5'd3, 5'd11, 5'd4};
    logic       tm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        expect_(o_run(cc), "exc_table_resume");
      end else if (k % 2 == 0) begin
        {misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
         misaligned_load_in, misaligned_store_in} = tv[k/2];
        cc = tc[k/2];
        expect_(o_trap(cc, 1'b0, tm[k/2]), $sformatf("exc_prio_%0d", k/2));
      end else begin
        {misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
         misaligned_load_in, misaligned_store_in} = '0;
        expect_(o_idle(cc, 1'b0), $sformatf("exc_trap_state_%0d", k/2));
      end
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_local_irq();
    out_t e; string s;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin
          local_irq_in = 4'b1010; local_irq_en_in = 4'hF; mie_in = 1'b1;
          cc = 5'd17; expect_(o_trap(cc, 1'b1, 1'b0), "local_irq1");
        end
        1: begin t_irq_in = 1'b1; mtie_in = 1'b1; expect_(o_idle(cc, 1'b0), "local_trap_state"); end
        2: begin cc = 5'd7; expect_(o_trap(cc, 1'b1, 1'b0), "timer_beats_local"); end
        3: begin t_irq_in = 1'b0; mtie_in = 1'b0; local_irq_en_in = 4'b1000; expect_(o_idle(cc, 1'b0), "timer_trap_state"); end
        4: begin cc = 5'd19; expect_(o_trap(cc, 1'b1, 1'b0), "local_irq_top_enabled"); end
        5: begin local_irq_in = 4'b0001; local_irq_en_in = 4'hF; mie_in = 1'b0; expect_(o_idle(cc, 1'b0), "local_top_trap_state"); end
        6: expect_(o_run(cc), "irq_masked_by_mie");
        default: begin local_irq_in = '0; expect_(o_run(cc), "local_idle"); end
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_wfi_wake();
    out_t e; string s;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: begin mie_in = 1'b0; wfi_in = 1'b1; s_irq_in = 1'b1; msie_in = 1'b1; expect_(o_wfi(cc, 1'b0), "wfi_with_pending"); end
        1: begin s_irq_in = 1'b0; expect_(o_wfi(cc, 1'b1), "wfi_sleep"); end
        2: begin wfi_in = 1'b0; expect_(o_idle(cc, 1'b1), "sleeping"); end
        3: begin s_irq_in = 1'b1; expect_(o_idle(cc, 1'b0), "wake_no_trap"); end
        4: begin s_irq_in = 1'b0; expect_(o_run(cc), "normal_after_wake"); end
        5: begin wfi_in = 1'b1; mie_in = 1'b1; expect_(o_wfi(cc, 1'b1), "wfi_sleep_mie"); end
        6: begin wfi_in = 1'b0; s_irq_in = 1'b1; stall_in = 1'b1; cc = 5'd3; expect_(o_trap(cc, 1'b1, 1'b0), "wake_trap_sw"); end
        7: begin s_irq_in = 1'b0; msie_in = 1'b0; stall_in = 1'b0; expect_(o_idle(cc, 1'b0), "wake_trap_state"); end
        default: expect_(o_run(cc), "wake_resume");
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_mret();
    out_t e; string s;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin mret_in = 1'b1; expect_(o_ret(cc), "mret"); end
        1: begin mret_in = 1'b0; expect_(o_idle(cc, 1'b0), "return_state"); end
        2: expect_(o_run(cc), "after_return");
        3: begin mret_in = 1'b1; e_irq_in = 1'b1; meie_in = 1'b1; cc = 5'd11; expect_(o_trap(cc, 1'b1, 1'b0), "irq_beats_mret"); end
        4: begin mret_in = 1'b0; e_irq_in = 1'b0; meie_in = 1'b0; expect_(o_idle(cc, 1'b0), "irq_mret_trap_state"); end
        default: expect_(o_run(cc), "mret_resume");
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    out_t e; string s;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin stall_in = 1'b1; misaligned_store_in = 1'b1; expect_(o_idle(cc, 1'b0), "stall_blocks_exc"); end
        1: expect_(o_idle(cc, 1'b0), "stall_hold");
        2: begin stall_in = 1'b0; cc = 5'd6; expect_(o_trap(cc, 1'b0, 1'b1), "store_misaligned"); end
        3: begin misaligned_store_in = 1'b0; expect_(o_idle(cc, 1'b0), "store_trap_state"); end
        default: expect_(o_run(cc), "stall_resume");
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    out_t e; string s;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin illegal_instr_in = 1'b1; cc = 5'd2; expect_(o_trap(cc, 1'b0, 1'b0), "b2b_first"); end
        1: expect_(o_idle(cc, 1'b0), "b2b_gap");
        2: expect_(o_trap(cc, 1'b0, 1'b0), "b2b_second");
        3: begin illegal_instr_in = 1'b0; expect_(o_idle(cc, 1'b0), "b2b_gap2"); end
        default: expect_(o_run(cc), "b2b_resume");
      endcase
      @(posedge clk_in); #1;
      e = sb.pop_front(); s = nm.pop_front(); n_chk++;
      if (norm(obs) !== norm(e)) $display("FAIL %s: got %h required %h", s, obs, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sleep_reset();
    test_exc_priority();
    test_exc_table();
    test_local_irq();
    test_wfi_wake();
    test_mret();
    test_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
